// File: rtl/alu_seq_muldiv_pkg.sv
// Shared opcodes, FSM state encoding and width constants for the
// multi-cycle ALU and its decoder.
package alu_pkg;

    localparam int OP_W = 4;
    localparam int ST_W = 2;

    localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_MUL  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_DIVU = 4'b0100;
    localparam logic [OP_W-1:0] ALU_REMU = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Request/response bundle between the EX stage and the multi-cycle ALU.
// Handshake: a request transfers on in_valid && in_ready && !flush; a result
// transfers on out_valid && out_ready; flush aborts everything in flight.
interface alu_seq_muldiv_if
    import alu_pkg::*;
#(
    parameter int XLEN = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  alu_control;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  rd;
    logic             alu_zero;
    logic             busy;
    logic             flush;
    logic [ST_W-1:0]  state;

    modport master (
        output in_valid, alu_control, rs1, rs2, out_ready, flush,
        input  in_ready, out_valid, rd, alu_zero, busy, state
    );

    modport slave (
        input  in_valid, alu_control, rs1, rs2, out_ready, flush,
        output in_ready, out_valid, rd, alu_zero, busy, state
    );
endinterface

// File: rtl/alu_seq_muldiv_simple_ops.sv
// Single-cycle AND/OR/ADD/SUB datapath; unknown opcodes yield zero.
module alu_simple_ops
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [OP_W-1:0] i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU: simple ops in one cycle, shift-add MUL and restoring
// DIVU/REMU at one bit per cycle, behind a valid/ready handshake.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [ST_W-1:0]  r_state;
    logic [XLEN-1:0]  r_rd;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_op;
    // r_a: multiplicand (MUL) or dividend/quotient shifter (DIV)
    // r_b: multiplier (MUL) or divisor (DIV)
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  r_rem;

    logic             w_accept;
    logic             w_is_div;
    logic [XLEN-1:0]  w_simple;
    logic [XLEN-1:0]  w_acc_nxt;
    logic [XLEN:0]    w_rem_sh;
    logic [XLEN:0]    w_diff;
    logic [XLEN-1:0]  w_rem_nxt;
    logic [XLEN-1:0]  w_quo_nxt;

    alu_simple_ops #(.XLEN(XLEN)) u_simple (
        .i_op     (bus.alu_control),
        .i_a      (bus.rs1),
        .i_b      (bus.rs2),
        .o_result (w_simple)
    );

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE) && !bus.flush;
    assign w_is_div  = (bus.alu_control == ALU_DIVU) || (bus.alu_control == ALU_REMU);
    assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);

    // Remainder runs one bit wider so the borrow of the trial subtract is bit XLEN.
    assign w_rem_sh  = {r_rem, r_a[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_rem_nxt = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_nxt = {r_a[XLEN-2:0], ~w_diff[XLEN]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
        end else if (bus.flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= bus.alu_control;
                        if (bus.alu_control == ALU_MUL || (w_is_div && bus.rs2 != '0)) begin
                            r_a     <= bus.rs1;
                            r_b     <= bus.rs2;
                            r_acc   <= '0;
                            r_rem   <= '0;
                            r_cnt   <= CNT_W'(XLEN);
                            r_state <= ST_BUSY;
                        end else begin
                            if (w_is_div)
                                r_rd <= (bus.alu_control == ALU_DIVU) ? '1 : bus.rs1;
                            else
                                r_rd <= w_simple;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_op == ALU_MUL) begin
                        r_acc <= w_acc_nxt;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_a   <= w_quo_nxt;
                    end
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_op == ALU_MUL)       r_rd <= w_acc_nxt;
                        else if (r_op == ALU_DIVU) r_rd <= w_quo_nxt;
                        else                       r_rd <= w_rem_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.rd        = r_rd;
    assign bus.alu_zero  = (r_rd == '0);
    assign bus.state     = r_state;
endmodule
